// File: rtl/seq_div_8bit_pkg.sv
// seq_div_8bit_pkg
//   Shared definitions for the iterative restoring divider.
//   Contents:
//     div_state_e - controller states (IDLE=0, RUN=1, DONE=2)
//     div_cnt_w   - width of the step counter for a given operand width
package seq_div_8bit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // One extra bit so the counter can hold the value WIDTH itself.
  function automatic int div_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_div_8bit_step.sv
// seq_div_8bit_step
//   Combinational single step of an unsigned restoring divider.
//   Ports:
//     r_in   in  WIDTH    low WIDTH bits of the partial remainder R
//     q_msb  in  1        current MSB of the quotient/dividend shift register
//     d      in  WIDTH    divisor
//     r_out  out WIDTH+1  next partial remainder
//     q_bit  out 1        retired quotient bit (1 = subtract succeeded)
module seq_div_8bit_step
  import seq_div_8bit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] sum;

  // Subtract as a + ~b + 1; the carry out of the WIDTH+1 bit add is the
  // inverted borrow, so it doubles as the quotient bit.
  always_comb begin
    shifted = {r_in, q_msb};
    sum     = {1'b0, shifted} + {1'b0, ~{1'b0, d}} + {{(WIDTH+1){1'b0}}, 1'b1};
    q_bit   = sum[WIDTH+1];
    r_out   = q_bit ? sum[WIDTH:0] : shifted;
  end

endmodule

// File: rtl/seq_div_8bit.sv
// seq_div_8bit
//   Iterative unsigned restoring divider, one quotient bit per clock, with a
//   start/busy/done handshake.
//   Ports:
//     clk        in  1      rising-edge clock
//     rst_n      in  1      asynchronous active-low reset
//     start      in  1      request, sampled only while busy=0
//     dividend   in  WIDTH  numerator, captured on accepted start
//     divisor    in  WIDTH  denominator, captured on accepted start
//     busy       out 1      operation in flight (RUN)
//     done       out 1      one-cycle result-valid pulse (DONE)
//     quotient   out WIDTH  floor(dividend/divisor), held until next result
//     remainder  out WIDTH  dividend mod divisor, held until next result
//     div0       out 1      divide-by-zero flag, valid with done
//   Build option:
//     DIV_BYZERO_EN - when defined, a zero divisor skips the iteration and
//                     reports div0=1 one cycle after accept. When undefined,
//                     a zero divisor runs all steps and div0 is always 0.
module seq_div_8bit
  import seq_div_8bit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0
);

  localparam int CNT_W = div_cnt_w(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH:0]   step_r;
  logic             step_q_bit;
  logic             last_step;
  logic             skip_run;

  // R never reaches the divisor, so its top bit is always zero once stored.
  logic             unused_r_msb;
  assign unused_r_msb = r_q[WIDTH];

  seq_div_8bit_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (r_q[WIDTH-1:0]),
    .q_msb (q_q[WIDTH-1]),
    .d     (d_q),
    .r_out (step_r),
    .q_bit (step_q_bit)
  );

  assign last_step = (cnt_q == CNT_W'(1));

`ifdef DIV_BYZERO_EN
  logic div0_q, div0_d;
  assign skip_run = (divisor == '0);
`else
  assign skip_run = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE behaves like IDLE so a held start chains operations.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE, DIV_DONE: begin
        if (start) state_d = skip_run ? DIV_DONE : DIV_RUN;
        else       state_d = DIV_IDLE;
      end
      DIV_RUN: begin
        if (last_step) state_d = DIV_DONE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // Datapath: load on accept, one restoring step per RUN cycle, and capture
  // the results only on the step that enters DONE.
  always_comb begin
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIV_BYZERO_EN
    div0_d      = div0_q;
`endif
    if (state_q == DIV_RUN) begin
      r_d   = step_r;
      q_d   = {q_q[WIDTH-2:0], step_q_bit};
      cnt_d = cnt_q - CNT_W'(1);
      if (last_step) begin
        quotient_d  = {q_q[WIDTH-2:0], step_q_bit};
        remainder_d = step_r[WIDTH-1:0];
`ifdef DIV_BYZERO_EN
        div0_d      = 1'b0;
`endif
      end
    end else if (start && (state_q == DIV_IDLE || state_q == DIV_DONE)) begin
      r_d   = '0;
      q_d   = dividend;
      d_d   = divisor;
      cnt_d = CNT_W'(WIDTH);
`ifdef DIV_BYZERO_EN
      if (skip_run) begin
        quotient_d  = '1;
        remainder_d = dividend;
        div0_d      = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_BYZERO_EN
      div0_q      <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef DIV_BYZERO_EN
      div0_q      <= div0_d;
`endif
    end
  end

  // Outputs
  always_comb begin
    busy      = (state_q == DIV_RUN);
    done      = (state_q == DIV_DONE);
    quotient  = quotient_q;
    remainder = remainder_q;
  end

`ifdef DIV_BYZERO_EN
  assign div0 = div0_q;
`else
  assign div0 = 1'b0;
`endif

endmodule
